// File: rtl/ahb_slave_mux_n.sv
// AHB-Lite slave-side interconnect: address decode, data-phase response mux,
// built-in default (ERROR) slave and a saturating completed-error counter.
module ahb_slave_mux_n #(
   parameter int unsigned NUM_SLAVES = 2,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SLOT_LSB   = 10,
   parameter int unsigned SLOT_BITS  = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic [ADDR_W-1:0]            HADDR,
   input  logic [1:0]                   HTRANS,
   input  logic                         HWRITE,
   output logic [NUM_SLAVES-1:0]        HSEL_S,
   input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]        HRESP_S,
   output logic                         HREADY,
   output logic [DATA_W-1:0]            HRDATA,
   output logic                         HRESP,
   input  logic                         ERR_CLR,
   output logic [CNT_W-1:0]             ERR_COUNT
);

   // First address past the contiguous slave map (one extra bit avoids overflow).
   localparam logic [ADDR_W:0] MAP_TOP = (ADDR_W+1)'(NUM_SLAVES) << SLOT_LSB;

   typedef enum logic [1:0] {
      DS_NONE,
      DS_SLAVE,
      DS_DEFAULT
   } dsel_kind_t;

   typedef enum logic [1:0] {
      DF_IDLE,
      DF_ERR1,
      DF_ERR2
   } dflt_state_t;

   logic                 mapped;
   logic [SLOT_BITS-1:0] slot;
   logic                 err_start;

   dsel_kind_t           dsel_kind, dsel_kind_nxt;
   logic [SLOT_BITS-1:0] dsel_idx, dsel_idx_nxt;
   dflt_state_t          state, state_nxt;
   logic [CNT_W-1:0]     err_count;

   // Direction and the SEQ/NONSEQ distinction do not affect routing.
   logic unused_inputs;
   assign unused_inputs = ^{HWRITE, HTRANS[0]};

   assign mapped    = ({1'b0, HADDR} < MAP_TOP);
   assign slot      = HADDR[SLOT_LSB +: SLOT_BITS];
   assign err_start = HREADY && HTRANS[1] && !mapped;
   assign ERR_COUNT = err_count;

   // One-hot slave select, independent of HTRANS.
   always_comb begin
      HSEL_S = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (mapped && (slot == SLOT_BITS'(i))) begin
            HSEL_S[i] = 1'b1;
         end
      end
   end

   // Data-phase select follows the decode on every accepted cycle, else holds.
   always_comb begin
      dsel_kind_nxt = dsel_kind;
      dsel_idx_nxt  = dsel_idx;
      if (HREADY) begin
         dsel_idx_nxt = slot;
         if (mapped) begin
            dsel_kind_nxt = DS_SLAVE;
         end else if (HTRANS[1]) begin
            dsel_kind_nxt = DS_DEFAULT;
         end else begin
            dsel_kind_nxt = DS_NONE;
         end
      end
   end

   // Default slave next state: two-cycle ERROR per unmapped active transfer.
   always_comb begin
      state_nxt = state;
      case (state)
         DF_IDLE: if (err_start) state_nxt = DF_ERR1;
         DF_ERR1: state_nxt = DF_ERR2;
         DF_ERR2: state_nxt = err_start ? DF_ERR1 : DF_IDLE;
         default: state_nxt = DF_IDLE;
      endcase
   end

   // Response mux; default-slave outputs are decoded straight from its state
   // so the FSM next-state logic can depend on HREADY without a loop.
   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      case (dsel_kind)
         DS_SLAVE: begin
            for (int i = 0; i < int'(NUM_SLAVES); i++) begin
               if (dsel_idx == SLOT_BITS'(i)) begin
                  HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
                  HREADY = HREADYOUT_S[i];
                  HRESP  = HRESP_S[i];
               end
            end
         end
         DS_DEFAULT: begin
            HREADY = (state != DF_ERR1);
            HRESP  = (state != DF_IDLE);
         end
         default: begin
            HRDATA = '0;
            HREADY = 1'b1;
            HRESP  = 1'b0;
         end
      endcase
   end

   // Select and default-slave state registers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dsel_kind <= DS_NONE;
         dsel_idx  <= '0;
         state     <= DF_IDLE;
      end else begin
         dsel_kind <= dsel_kind_nxt;
         dsel_idx  <= dsel_idx_nxt;
         state     <= state_nxt;
      end
   end

   // Count completed ERROR responses; clear has priority, saturates at all-ones.
   always_ff @(posedge HCLK) begin
      if (HRESET || ERR_CLR) begin
         err_count <= '0;
      end else if (HREADY && HRESP && (err_count != {CNT_W{1'b1}})) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: doc/ahb_slave_mux_n.md
Name: ahb_slave_mux_n

Overview:
Parametrised AHB-Lite slave-side interconnect for NUM_SLAVES memory slaves. It decodes HADDR into one-hot HSEL_S and registers the address-phase selection. It multiplexes HRDATA/HREADYOUT/HRESP back to the master in the data phase. It contains a built-in default slave that returns the spec-correct two-cycle ERROR for unmapped accesses, plus a saturating error-response counter for debug.

Parameters:
NUM_SLAVES, 2, number of slave channels (1..16)
ADDR_W, 32, HADDR width
DATA_W, 32, HRDATA/HWDATA width
SLOT_LSB, 10, log2 of bytes per slave region; slot index = HADDR[SLOT_LSB +: SLOT_BITS]
SLOT_BITS, 2, index width; NUM_SLAVES <= 2**SLOT_BITS
CNT_W, 16, error counter width

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESET  in  1  synchronous reset, active-high
HADDR  in  ADDR_W  master address
HTRANS  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
HWRITE  in  1  direction (decode only; not used by mux)
HSEL_S  out  NUM_SLAVES  one-hot slave select, combinational from HADDR
HRDATA_S  in  NUM_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
HREADYOUT_S  in  NUM_SLAVES  per-slave ready
HRESP_S  in  NUM_SLAVES  per-slave response (1 = ERROR)
HREADY  out  1  muxed ready to master and all slaves
HRDATA  out  DATA_W  muxed read data
HRESP  out  1  muxed response
ERR_CLR  in  1  synchronous clear of ERR_COUNT
ERR_COUNT  out  CNT_W  completed ERROR responses, saturating

Behaviour:
- Mapped: HADDR < NUM_SLAVES * 2**SLOT_LSB, comparison >= gives unmapped. Mapped → HSEL_S[slot]=1, others 0. Unmapped → HSEL_S all 0, default slave selected.
- HSEL_S is driven irrespective of HTRANS; slaves qualify with HTRANS and HREADY.
- Data-phase select register dsel (slave index, DEFAULT, or NONE):
  - Loaded every cycle with HREADY=1 from the current decode.
  - HTRANS IDLE/BUSY loads NONE for unmapped addresses. It loads the slave index for mapped addresses; the slave gives zero-wait OKAY.
  - Held while HREADY=0.
- Output mux:
  - dsel=i → HRDATA=HRDATA_S[i], HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i].
  - dsel=NONE → HRDATA=0, HREADY=1, HRESP=0.
  - dsel=DEFAULT → HRDATA=0, HREADY and HRESP from the default FSM.
- Default slave FSM (states IDLE, ERR1, ERR2):
  - IDLE→ERR1 when HREADY=1 & HTRANS[1]=1 & unmapped.
  - ERR1: HRESP=1, HREADY=0; always →ERR2.
  - ERR2: HRESP=1, HREADY=1. →ERR1 if another NONSEQ/SEQ to an unmapped address is sampled this cycle, else →IDLE.
  - In IDLE the FSM drives HRESP=0, HREADY=1.
- Latency: the mux adds zero cycles. Data-phase outputs follow dsel combinationally; dsel is one register stage after the address phase.
- ERR_COUNT:
  - Increments on a cycle with HREADY=1 & HRESP=1. This covers both slave and default errors, counting once per completed ERROR response (not on the first ERROR cycle).
  - Saturates at 2**CNT_W-1.
  - ERR_CLR=1 zeroes it; clear wins over a simultaneous increment.
- Reset (HRESET=1 at an edge), including mid-transfer or mid-ERROR:
  - dsel=NONE, FSM=IDLE, ERR_COUNT=0.
  - Outputs then: HREADY=1, HRESP=0, HRDATA=0. HSEL_S still follows HADDR.
- Back-to-back transfers to different slaves: the new slave is selected in its address phase while the old slave's data is still muxed. dsel switches only at the HREADY=1 edge.
- Slot index ≥ NUM_SLAVES but HADDR below the top boundary cannot occur (the map is contiguous). Addresses above the boundary wrap to no slave.

Test Plan:
- Reset then idle bus → HREADY=1, HRESP=0, HRDATA=0, ERR_COUNT=0; HADDR=0x400 gives HSEL_S=2'b10.
- NONSEQ read 0x004 with slave0 HRDATA_S=0xA5A5A5A5 and 1 wait state → HREADY low 1 cycle, then HRDATA=0xA5A5A5A5, HRESP=0.
- Pipelined NONSEQ 0x000 (slave0) then 0x404 (slave1), slave0 stalls 2 cycles → HRDATA follows slave0 until its HREADYOUT=1, then slave1 data next cycle.
- NONSEQ to 0x800 (unmapped, NUM_SLAVES=2) → HSEL_S=0; data phase HREADY=0/HRESP=1 then HREADY=1/HRESP=1; ERR_COUNT=1.
- IDLE to 0x800 → HREADY=1, HRESP=0, ERR_COUNT unchanged. HRESET asserted in ERR1 → next cycle HREADY=1, HRESP=0, ERR_COUNT=0.
- CNT_W=2: five unmapped NONSEQ → ERR_COUNT saturates at 3. ERR_CLR coincident with an ERR2 cycle → ERR_COUNT=0.
